// File: rtl/stencil_pkg.sv
// Shared constants and helpers for the KxK streaming stencil.
// Optional build macro: STENCIL_CONV_SAT_EN (saturating output).
package stencil_pkg;

  localparam int K_MIN = 2;
  localparam int K_MAX = 7;
  localparam int PIX_W = 16;

  typedef logic [PIX_W-1:0] pix_t;

  function automatic int acc_w(input int w, input int k);
    return w + $clog2(k * k);
  endfunction

endpackage

// File: rtl/stencil_line_buf.sv
// One-row delay line: read-before-write at the same column address.
// Optional build macro: STENCIL_CONV_SAT_EN (not used here).
module stencil_line_buf
  import stencil_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/stencil_conv_kxk.sv
// Streaming KxK box-sum over raster frames with valid/ready flow control.
// Optional build macro: STENCIL_CONV_SAT_EN (saturate instead of wrap).
module stencil_conv_kxk
  import stencil_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 3,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int ACC_W = acc_w(WIDTH, K)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_K1  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_K1  = RW'(K - 1);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             ov_q, ov_d;
  logic             ol_q, ol_d;
  logic [WIDTH-1:0] od_q, od_d;

  logic             accept;
  logic             complete;
  logic             frame_end;

  logic [WIDTH-1:0] lb_wr   [K-1];
  logic [WIDTH-1:0] lb_rd   [K-1];
  logic [WIDTH-1:0] new_col [K];
  logic [WIDTH-1:0] win_q   [K][K];
  logic [WIDTH-1:0] win_d   [K][K];
  logic [ACC_W-1:0] row_sum [K];
  logic [ACC_W-1:0] sum;
  logic [WIDTH-1:0] res;

  assign in_ready  = !ov_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign complete  = (row_q >= ROW_K1) && (col_q >= COL_K1);
  assign frame_end = (row_q == ROW_MAX) && (col_q == COL_MAX);

  // Line buffer 0 holds the previous row; each later one is a row older.
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_wr[i] = in_data;
    end else begin : g_tail
      assign lb_wr[i] = lb_rd[i-1];
    end
    stencil_line_buf #(
      .WIDTH(WIDTH),
      .DEPTH(IMG_W)
    ) u_lb (
      .clk    (clk),
      .we_i   (accept),
      .addr_i (col_q),
      .wdata_i(lb_wr[i]),
      .rdata_o(lb_rd[i])
    );
    assign new_col[K-2-i] = lb_rd[i];
  end
  assign new_col[K-1] = in_data;

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][K-1] = new_col[r];
    end
  end

  // Row partial sums feed a final reduction over the rows.
  always_comb begin
    sum = '0;
    for (int r = 0; r < K; r++) begin
      row_sum[r] = '0;
      for (int c = 0; c < K; c++) begin
        row_sum[r] = row_sum[r] + ACC_W'(win_d[r][c]);
      end
      sum = sum + row_sum[r];
    end
  end

`ifdef STENCIL_CONV_SAT_EN
  assign res = (|sum[ACC_W-1:WIDTH]) ? '1 : sum[WIDTH-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^sum[ACC_W-1:WIDTH];
  assign res = sum[WIDTH-1:0];
`endif

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    ol_d = ol_q;
    if (accept && complete) begin
      ov_d = 1'b1;
      od_d = res;
      ol_d = frame_end;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      ol_q  <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      ov_q  <= ov_d;
      od_q  <= od_d;
      ol_q  <= ol_d;
      if (accept) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            win_q[r][c] <= win_d[r][c];
          end
        end
      end
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;

endmodule

// File: tb/tb_stencil_conv_kxk.sv
// Directed bench for stencil_conv_kxk on a 5x4 frame, 3x3 kernel.
// Honours STENCIL_CONV_SAT_EN for the overflow expectation.
module tb_stencil_conv_kxk;

  localparam int W  = 16;
  localparam int K  = 3;
  localparam int IW = 5;
  localparam int IH = 4;
`ifdef STENCIL_CONV_SAT_EN
  localparam int SATV = 'hFFFF;
`else
  localparam int SATV = 'hFFF7;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_last;

  stencil_conv_kxk #(
    .WIDTH(W), .K(K), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int req_cnt = 0;
  int req_id = 0;
  int tmo_cnt = 0;
  bit rand_rdy = 1'b0;
  bit rdy_force = 1'b1;

  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  int RAMP[6] = '{54, 63, 72, 99, 108, 117};

  int img [IH][IW];
  int mr, mc, s, seen;
  int exp_d[$];
  bit exp_l[$];
  int got_d[$];
  bit got_l[$];
  bit prev_valid, prev_ready, prev_cmp, held, held_l;
  logic [W-1:0] held_d;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  function automatic int model_out(input int v);
`ifdef STENCIL_CONV_SAT_EN
    return (v > 'hFFFF) ? 'hFFFF : v;
`else
    return v & 'hFFFF;
`endif
  endfunction

  task automatic verify(input int id);
    int ev[$];
    bit el[$];
    int n;
    if (id == 99) begin
      chk("timeouts", tmo_cnt, 0);
      return;
    end
    for (int i = 0; i < 6; i++) begin
      case (id)
        1:       ev.push_back(9);
        4:       ev.push_back(SATV);
        default: ev.push_back(RAMP[i]);
      endcase
      el.push_back(i == 5);
    end
    if (id == 6) begin
      for (int i = 0; i < 6; i++) begin
        ev.push_back(18);
        el.push_back(i == 5);
      end
    end
    chk($sformatf("t%0d_count", id), got_d.size(), ev.size());
    n = (got_d.size() < ev.size()) ? got_d.size() : ev.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("t%0d_data%0d", id, i), got_d[i], ev[i]);
      chk($sformatf("t%0d_last%0d", id, i), got_l[i], el[i]);
    end
    got_d.delete();
    got_l.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_out", {out_valid, out_last, out_data}, 0);
      exp_d.delete();
      exp_l.delete();
      mr = 0;
      mc = 0;
      prev_valid = 0;
      prev_ready = 0;
      prev_cmp = 0;
      held = 0;
    end else begin
      chk("valid_timing", out_valid,
          prev_cmp || (prev_valid && !prev_ready));
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (held) chk("hold", {out_last, out_data}, {held_l, held_d});
      held   = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        chk("out_expected", exp_d.size() != 0, 1);
        if (exp_d.size() != 0) begin
          chk("model_data", out_data, exp_d.pop_front());
          chk("model_last", out_last, exp_l.pop_front());
        end
      end
      prev_cmp = 0;
      if (in_valid && in_ready) begin
        img[mr][mc] = in_data;
        if (mr >= K - 1 && mc >= K - 1) begin
          s = 0;
          for (int dr = 0; dr < K; dr++)
            for (int dc = 0; dc < K; dc++)
              s += img[mr-dr][mc-dc];
          exp_d.push_back(model_out(s));
          exp_l.push_back(mr == IH - 1 && mc == IW - 1);
          prev_cmp = 1;
        end
        mc++;
        if (mc == IW) begin
          mc = 0;
          mr = (mr == IH - 1) ? 0 : mr + 1;
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
    end
    if (req_cnt != seen) begin
      seen = req_cnt;
      verify(req_id);
    end
  end

  task automatic send(input int v, input bit gap);
    bit ok;
    if (gap && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = W'(v);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      tmo_cnt++;
      $display("FAIL send_timeout: actual stalled required accepted");
    end
  endtask

  task automatic send_frame(input bit ramp, input int val, input bit gap);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        send(ramp ? r * IW + c : val, gap);
  endtask

  task automatic drain_and_check(input int id);
    bit idle;
    in_valid = 1'b0;
    idle = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!out_valid) begin
        idle = 1;
        break;
      end
    end
    if (!idle) begin
      tmo_cnt++;
      $display("FAIL drain_timeout: actual busy required idle");
    end
    @(posedge clk);
    #1;
    rand_rdy = 1'b0;
    req_id = id;
    req_cnt++;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic stall_once();
    bit found;
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      tmo_cnt++;
      $display("FAIL stall_timeout: actual no output required output");
    end
    @(posedge clk);
    #1;
    rdy_force = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rdy_force = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_frame(0, 1, 0);
    drain_and_check(1);

    send_frame(1, 0, 0);
    drain_and_check(2);

    fork
      send_frame(1, 0, 0);
      stall_once();
    join
    drain_and_check(2);

    send_frame(0, 'hFFFF, 0);
    drain_and_check(4);

    for (int i = 0; i < 7; i++) send(i, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(1, 0, 0);
    drain_and_check(2);

    rand_rdy = 1'b1;
    send_frame(1, 0, 1);
    send_frame(0, 2, 1);
    drain_and_check(6);

    drain_and_check(99);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stencil_conv_kxk.md
Name: stencil_conv_kxk

Overview:
Streaming KxK box-sum stencil over a raster-ordered image. It generalises the fixed 3x3 naive conv compute: kernel size, pixel width, image width and height are all parameters. It adds valid/ready flow control, frame tracking, valid-window masking, and an end-of-frame marker. It sits between an input stream producer and an output consumer, and replaces the hand-unrolled ub plus shift-register buffer.

Parameters:
WIDTH, 16, pixel and output data width (unsigned)
K, 3, kernel edge length; legal range 2..7
IMG_W, 64, pixels per row; must be >= K
IMG_H, 64, rows per frame; must be >= K
ACC_W, WIDTH+$clog2(K*K), internal accumulator width (derived; do not override)

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  asynchronous reset, active-low
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel this cycle
in_data  in  WIDTH  input pixel, raster order (row-major, row 0 first)
out_valid  out  1  output sample valid
out_ready  in  1  consumer accepts output this cycle
out_data  out  WIDTH  KxK window sum
out_last  out  1  high with the final output sample of each frame

Behaviour:
- Reset (rst_n low, async assert, sync-released): out_valid=0, out_data=0, out_last=0; col/row counters=0; window registers=0. Line-buffer RAM is not cleared; stale data is masked by the counters.
- Handshake:
  - Input accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single output holding stage, no bubble at full rate).
  - Output transfer when out_valid && out_ready.
  - out_data and out_last hold stable while out_valid && !out_ready.
- Storage:
  - K-1 line buffers, each IMG_W deep x WIDTH, addressed by col.
  - On each accepted pixel, column col of every line buffer shifts up one row.
  - KxK window register array shifts left by one column; the new right column is {line buffers oldest..newest, in_data}.
- Counters:
  - col 0..IMG_W-1 and row 0..IMG_H-1 advance only on accepted input.
  - col wraps to 0 with row++ at IMG_W-1.
  - At col=IMG_W-1, row=IMG_H-1 both wrap to 0 (next frame starts immediately; no idle cycle required).
- Valid window: an accepted pixel at (row,col) completes a window iff row>=K-1 and col>=K-1. Only those pixels produce output, giving (IMG_W-K+1)*(IMG_H-K+1) outputs per frame. No padding is applied.
- Windows straddling a row wrap are never emitted, because the col>=K-1 mask applies.
- Latency: out_valid rises the cycle after the completing pixel is accepted (1 cycle).
- Arithmetic:
  - Unsigned sum of all K*K taps, computed as an adder tree in ACC_W bits.
  - out_data = sum[WIDTH-1:0] (modulo 2^WIDTH wrap), matching existing 16-bit wrap semantics.
- out_last is asserted with the output whose completing pixel is (IMG_H-1, IMG_W-1).
- Simultaneous events: output transfer and new completing pixel in the same cycle → output register reloads; no gap, no loss.
- Reset mid-frame: all counters return to 0; the next accepted pixel is treated as (0,0); partially accumulated frame output is discarded.

Optional Feature:
Macro STENCIL_CONV_SAT_EN.
- Defined: out_data = (sum > 2^WIDTH-1) ? {WIDTH{1'b1}} : sum[WIDTH-1:0] (unsigned saturation).
- Undefined: modulo wrap as above.
- Latency unchanged in both cases.

Decomposition:
- Shared package stencil_pkg:
  - function clog2-based ACC_W helper
  - typedef pix_t (logic [WIDTH-1:0]; default 16)
  - localparam constants for the legal K range
- One sub-module: stencil_line_buf, a single IMG_W x WIDTH delay-line RAM with read-before-write at the same address, instantiated K-1 times in a chain.
- Adder tree stays inline in the top module.

Test Plan:
1. IMG_W=5, IMG_H=4, K=3, all pixels 1, in_valid/out_ready held high → exactly 6 outputs each 9; out_last only on the 6th; first out_valid 1 cycle after pixel 12 (row2,col2) accepted.
2. Same geometry, pixel = row*5+col → outputs 9*(r*5+c) for centres (1,1)..(2,3): 54,63,72,99,108,117, in that order.
3. Backpressure: drop out_ready for 4 cycles while output pending → out_data held constant, in_ready=0, no sample lost or duplicated; sequence from test 2 intact.
4. Overflow: all pixels 0xFFFF → out_data=0xFFF7 without STENCIL_CONV_SAT_EN, 0xFFFF with it.
5. Reset mid-frame: pulse rst_n low after 7 pixels, then send a full ramp frame → exactly 6 outputs matching test 2; outputs 0 during and immediately after reset.
6. Two back-to-back frames with no gap, random in_valid/out_ready gaps → 12 outputs, out_last on the 6th and 12th, second frame values independent of the first.
